// File: rtl/bf_io_arbiter_if.sv
// Byte-stream arbiter bus: requester side, CPU input handshake and CPU output routing.
interface bf_io_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int SRC_W   = 3
);

  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_valid;
  logic [NUM_SRC-1:0]   src_ready;
  logic [7:0]           data_in;
  logic                 data_available;
  logic                 data_read;
  logic [7:0]           data_out;
  logic                 data_out_en;
  logic [7:0]           sink_data;
  logic [NUM_SRC-1:0]   sink_valid;
  logic [SRC_W-1:0]     owner;

  // Peripherals and CPU together drive requests and consume results.
  modport master (
    output src_data, src_valid, data_read, data_out, data_out_en,
    input  src_ready, data_in, data_available, sink_data, sink_valid, owner
  );

  // The arbiter itself.
  modport slave (
    input  src_data, src_valid, data_read, data_out, data_out_en,
    output src_ready, data_in, data_available, sink_data, sink_valid, owner
  );

endinterface

// File: rtl/bf_io_arbiter.sv
// Round-robin arbiter with optional burst lock that shares the CPU's single
// byte-input handshake between NUM_SRC requesters and routes CPU output bytes
// back to whichever requester supplied the last consumed input byte.
// The interface instance must use the same NUM_SRC and SRC_W as this module.
module bf_io_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int BURST   = 1,
  parameter int SRC_W   = 3
) (
  input logic         clk,
  input logic         rst_n,
  bf_io_arbiter_if.slave bus
);

  // Index space padded to a power of two so runtime indices select exactly.
  localparam int PAD_N = 2 ** SRC_W;
  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

  logic [PAD_N-1:0]   validPad;
  logic [8*PAD_N-1:0] dataPad;

  logic [7:0]         dataIn_q,    dataIn_d;
  logic               avail_q,     avail_d;
  logic [SRC_W-1:0]   holdSrc_q,   holdSrc_d;
  logic [SRC_W-1:0]   cur_q,       cur_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [SRC_W-1:0]   owner_q,     owner_d;
  logic [7:0]         sinkData_q,  sinkData_d;
  logic [NUM_SRC-1:0] sinkValid_q, sinkValid_d;

  logic [SRC_W:0]     probe;
  logic [SRC_W-1:0]   scanSel;
  logic [SRC_W-1:0]   sel;
  logic               locked;
  logic               acc;
  logic               xfer;
  logic [PAD_N-1:0]   selHot;
  logic [PAD_N-1:0]   ownerHot;
  logic [CNT_W:0]     cntInc;

  assign validPad = PAD_N'(bus.src_valid);
  assign dataPad  = (8*PAD_N)'(bus.src_data);

  // Round-robin scan starting after cur; smaller offsets overwrite larger ones,
  // so the nearest valid requester wins and cur itself is taken only as last resort.
  always_comb begin
    probe   = '0;
    scanSel = cur_q;
    for (int k = NUM_SRC; k >= 1; k--) begin
      probe = {1'b0, cur_q} + (SRC_W+1)'(k);
      if (probe >= (SRC_W+1)'(NUM_SRC)) begin
        probe = probe - (SRC_W+1)'(NUM_SRC);
      end
      if (validPad[probe[SRC_W-1:0]]) begin
        scanSel = probe[SRC_W-1:0];
      end
    end
  end

  assign locked   = (cnt_q != '0) && validPad[cur_q];
  assign sel      = locked ? cur_q : scanSel;
  assign acc      = !avail_q || bus.data_read;
  assign xfer     = acc && (|bus.src_valid);
  assign selHot   = PAD_N'(1) << sel;
  assign ownerHot = PAD_N'(1) << owner_q;
  assign cntInc   = {1'b0, cnt_q} + (CNT_W+1)'(1);

  // Holding register, burst counter, owner tracking and output routing next state.
  always_comb begin
    dataIn_d    = dataIn_q;
    avail_d     = avail_q;
    holdSrc_d   = holdSrc_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    sinkData_d  = bus.data_out;
    sinkValid_d = bus.data_out_en ? ownerHot[NUM_SRC-1:0] : '0;

    if (avail_q && bus.data_read) begin
      owner_d = holdSrc_q;
    end

    if (xfer) begin
      dataIn_d  = dataPad[{sel, 3'b000} +: 8];
      avail_d   = 1'b1;
      cur_d     = sel;
      holdSrc_d = sel;
      if (locked) begin
        cnt_d = (cntInc == (CNT_W+1)'(BURST)) ? '0 : cntInc[CNT_W-1:0];
      end else begin
        cnt_d = (BURST == 1) ? '0 : CNT_W'(1);
      end
    end else begin
      if (avail_q && bus.data_read) begin
        avail_d = 1'b0;
      end
      if ((cnt_q != '0) && !validPad[cur_q]) begin
        cnt_d = '0;
      end
    end
  end

  // State register with synchronous active-low reset; reset drops the held byte and any lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dataIn_q    <= '0;
      avail_q     <= 1'b0;
      holdSrc_q   <= '0;
      cur_q       <= '0;
      cnt_q       <= '0;
      owner_q     <= '0;
      sinkData_q  <= '0;
      sinkValid_q <= '0;
    end else begin
      dataIn_q    <= dataIn_d;
      avail_q     <= avail_d;
      holdSrc_q   <= holdSrc_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      sinkData_q  <= sinkData_d;
      sinkValid_q <= sinkValid_d;
    end
  end

  assign bus.src_ready      = xfer ? selHot[NUM_SRC-1:0] : '0;
  assign bus.data_in        = dataIn_q;
  assign bus.data_available = avail_q;
  assign bus.sink_data      = sinkData_q;
  assign bus.sink_valid     = sinkValid_q;
  assign bus.owner          = owner_q;

endmodule

// File: tb/tb_bf_io_arbiter.sv
// Directed bench for bf_io_arbiter: one pure round-robin instance (BURST=1)
// and one burst instance (BURST=3), both with two requesters.
module tb_bf_io_arbiter;

  logic clk;
  logic rst_n;

  int vecCount;
  int missCount;

  bf_io_arbiter_if #(.NUM_SRC(2), .SRC_W(3)) busA ();
  bf_io_arbiter_if #(.NUM_SRC(2), .SRC_W(3)) busB ();

  bf_io_arbiter #(.NUM_SRC(2), .BURST(1), .SRC_W(3)) dutRr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  bf_io_arbiter #(.NUM_SRC(2), .BURST(3), .SRC_W(3)) dutBurst (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the requester side and data_read of instance 0 (round robin) or 1 (burst).
  task automatic applyStimulus(input int which, input logic [15:0] data,
                               input logic [1:0] valid, input logic read);
    if (which == 0) begin
      busA.src_data  = data;
      busA.src_valid = valid;
      busA.data_read = read;
    end else begin
      busB.src_data  = data;
      busB.src_valid = valid;
      busB.data_read = read;
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    rst_n     = 1'b0;
    applyStimulus(0, 16'h0000, 2'b00, 1'b0);
    applyStimulus(1, 16'h0000, 2'b00, 1'b0);
    busA.data_out    = 8'h00;
    busA.data_out_en = 1'b0;
    busB.data_out    = 8'h00;
    busB.data_out_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state.
    checkOutput("rst_avail", 32'(busA.data_available), 32'h0);
    checkOutput("rst_data_in", 32'(busA.data_in), 32'h0);
    checkOutput("rst_owner", 32'(busA.owner), 32'h0);
    checkOutput("rst_sink_valid", 32'(busA.sink_valid), 32'h0);
    checkOutput("rst_ready", 32'(busA.src_ready), 32'h0);

    // Output strobe before any input consumed goes to requester 0.
    busA.data_out    = 8'h55;
    busA.data_out_en = 1'b1;
    tick();
    checkOutput("early_sink_valid", 32'(busA.sink_valid), 32'h1);
    checkOutput("early_sink_data", 32'(busA.sink_data), 32'h55);
    busA.data_out_en = 1'b0;
    tick();
    checkOutput("early_sink_clear", 32'(busA.sink_valid), 32'h0);

    // Single requester, no reads: one-edge latency then hold steady.
    applyStimulus(0, 16'h0041, 2'b01, 1'b0);
    #1;
    checkOutput("t1_ready_pre", 32'(busA.src_ready), 32'h1);
    tick();
    checkOutput("t1_avail", 32'(busA.data_available), 32'h1);
    checkOutput("t1_data_in", 32'(busA.data_in), 32'h41);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("t1_ready_hold%0d", i), 32'(busA.src_ready), 32'h0);
      tick();
      checkOutput($sformatf("t1_data_hold%0d", i), 32'(busA.data_in), 32'h41);
    end

    // Drain with no new transfer empties the register.
    applyStimulus(0, 16'h0041, 2'b00, 1'b1);
    tick();
    checkOutput("drain_avail", 32'(busA.data_available), 32'h0);

    // Read pulsed while EMPTY with nothing valid changes nothing.
    #1;
    checkOutput("t6_ready", 32'(busA.src_ready), 32'h0);
    tick();
    checkOutput("t6_avail", 32'(busA.data_available), 32'h0);
    checkOutput("t6_owner", 32'(busA.owner), 32'h0);
    checkOutput("t6_data_in", 32'(busA.data_in), 32'h41);
    applyStimulus(0, 16'h0000, 2'b00, 1'b0);

    // Pure round robin, reads every cycle: src1 first, then alternate with no bubbles.
    applyStimulus(0, 16'h2010, 2'b11, 1'b1);
    #1;
    checkOutput("t2_ready_pre", 32'(busA.src_ready), 32'h2);
    for (int i = 1; i <= 6; i++) begin
      tick();
      checkOutput($sformatf("t2_data%0d", i), 32'(busA.data_in),
                  (i % 2 == 1) ? 32'h20 : 32'h10);
      checkOutput($sformatf("t2_avail%0d", i), 32'(busA.data_available), 32'h1);
      if (i >= 2) begin
        checkOutput($sformatf("t2_owner%0d", i), 32'(busA.owner),
                    (i % 2 == 0) ? 32'h1 : 32'h0);
      end
    end
    applyStimulus(0, 16'h0000, 2'b00, 1'b1);
    tick();
    checkOutput("t2_drain_avail", 32'(busA.data_available), 32'h0);
    checkOutput("t2_drain_owner", 32'(busA.owner), 32'h0);

    // Consume a byte from src1, then route an output byte back to it.
    applyStimulus(0, 16'h3300, 2'b10, 1'b0);
    tick();
    checkOutput("t4_hold", 32'(busA.data_in), 32'h33);
    applyStimulus(0, 16'h0000, 2'b00, 1'b1);
    tick();
    checkOutput("t4_owner", 32'(busA.owner), 32'h1);
    applyStimulus(0, 16'h0000, 2'b00, 1'b0);
    busA.data_out    = 8'h7A;
    busA.data_out_en = 1'b1;
    tick();
    checkOutput("t4_sink_valid", 32'(busA.sink_valid), 32'h2);
    checkOutput("t4_sink_data", 32'(busA.sink_data), 32'h7A);

    // Strobe in the same cycle as a read goes to the previous owner.
    busA.data_out_en = 1'b0;
    applyStimulus(0, 16'h0044, 2'b01, 1'b0);
    tick();
    checkOutput("t4_hold0", 32'(busA.data_in), 32'h44);
    applyStimulus(0, 16'h0000, 2'b00, 1'b1);
    busA.data_out    = 8'h99;
    busA.data_out_en = 1'b1;
    tick();
    checkOutput("t4_prev_owner_sink", 32'(busA.sink_valid), 32'h2);
    checkOutput("t4_new_owner", 32'(busA.owner), 32'h0);
    applyStimulus(0, 16'h0000, 2'b00, 1'b0);
    busA.data_out_en = 1'b0;
    tick();
    checkOutput("t4_sink_idle", 32'(busA.sink_valid), 32'h0);

    // Burst of 3: grant order 1,1,1,0,0,0,1 with reads every cycle.
    applyStimulus(1, 16'h2010, 2'b11, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      #1;
      checkOutput($sformatf("t3_ready%0d", i), 32'(busB.src_ready),
                  (i <= 3 || i == 7) ? 32'h2 : 32'h1);
      tick();
      checkOutput($sformatf("t3_data%0d", i), 32'(busB.data_in),
                  (i <= 3 || i == 7) ? 32'h20 : 32'h10);
    end

    // src1 drops right after its first burst byte: grant moves to src0 at once.
    applyStimulus(1, 16'h2010, 2'b01, 1'b1);
    #1;
    checkOutput("t3_drop_ready", 32'(busB.src_ready), 32'h1);
    tick();
    checkOutput("t3_drop_data", 32'(busB.data_in), 32'h10);
    checkOutput("t3_drop_owner", 32'(busB.owner), 32'h1);

    // Reset while FULL mid-burst, then expect a fresh round-robin order.
    applyStimulus(1, 16'h2010, 2'b11, 1'b0);
    rst_n = 1'b0;
    tick();
    checkOutput("t5_avail", 32'(busB.data_available), 32'h0);
    checkOutput("t5_owner", 32'(busB.owner), 32'h0);
    checkOutput("t5_data_in", 32'(busB.data_in), 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("t5_fresh_ready", 32'(busB.src_ready), 32'h2);
    tick();
    checkOutput("t5_fresh_data", 32'(busB.data_in), 32'h20);
    checkOutput("t5_full_ready", 32'(busB.src_ready), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/bf_io_arbiter.md
Name: bf_io_arbiter

Overview:
- Shares the CPU's single byte-input handshake (data_in / data_available / data_read) between NUM_SRC byte-stream requesters, for example a UART and a host-debug port.
- Uses round-robin arbitration with an optional burst lock, so one requester can deliver several consecutive bytes.
- Routes each CPU output byte (data_out / data_out_en) back to the requester that supplied the most recently consumed input byte.
- Sits between the I/O peripherals and the cpu top level.

Parameters:
- NUM_SRC, 2: number of requesters, 1..8.
- BURST, 1: maximum consecutive bytes granted to one requester while it stays valid. 1 gives pure round robin.
- SRC_W, 3: width of the index fields; must satisfy 2**SRC_W >= NUM_SRC.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- src_data  in  8*NUM_SRC  byte from each requester; requester i drives bits [8i+7:8i].
- src_valid  in  NUM_SRC  requester i has a byte.
- src_ready  out  NUM_SRC  one-hot or zero; a transfer occurs when src_valid[i] & src_ready[i].
- data_in  out  8  held byte presented to the CPU.
- data_available  out  1  held byte is valid.
- data_read  in  1  CPU consumes the held byte this cycle.
- data_out  in  8  CPU output byte.
- data_out_en  in  1  CPU output strobe.
- sink_data  out  8  registered copy of data_out.
- sink_valid  out  NUM_SRC  one-hot strobe to the owning requester.
- owner  out  SRC_W  index of the requester whose byte was last consumed.

Behaviour:
- Reset (rst_n=0 at a rising edge) sets data_available=0, data_in=0, sink_data=0, sink_valid=0, owner=0, cur=0, cnt=0.
- Reset mid-operation discards the held byte and cancels any burst lock.
- Holding register: one entry with two states.
  - EMPTY (data_available=0).
  - FULL (data_available=1).
- Accept opportunity (acc) = EMPTY, or FULL with data_read=1 in the same cycle.
- src_ready is combinational: equals onehot(sel) when acc is true and any src_valid is set, otherwise 0.
- Grant selection (sel):
  - Lock case: if cnt != 0 and src_valid[cur], sel = cur.
  - Otherwise, sel is the first valid index found scanning cur+1, cur+2, ... with wrap modulo NUM_SRC, with cur checked last.
- On a transfer:
  - data_in <= src_data[sel], data_available <= 1, cur <= sel.
  - If this is a locked continuation, cnt <= (cnt+1 == BURST) ? 0 : cnt+1.
  - Otherwise, cnt <= (BURST == 1) ? 0 : 1.
- If the locked requester drops src_valid: cnt <= 0 at that edge and the normal round-robin search is used.
- Latency: a byte accepted at edge N appears on data_in with data_available=1 after edge N. There is no combinational path from src_data to data_in.
- Back-to-back: data_read=1 together with a new transfer keeps data_available=1 and replaces data_in, giving zero bubbles.
- data_read=1 with no transfer: the register goes to EMPTY and data_available <= 0.
- data_read while EMPTY is ignored; no state change.
- Owner tracking:
  - Each byte carries its source index in a side register.
  - owner <= that index on the edge where the byte is consumed (data_read=1 while FULL).
- Output routing:
  - sink_data <= data_out every edge.
  - sink_valid <= data_out_en ? onehot(owner) : 0. This uses owner's pre-edge value.
  - With data_out_en and data_read in the same cycle, the output goes to the previous owner.
  - Output before any input is consumed goes to requester 0.
- NUM_SRC=1: degenerates to a one-byte pipeline register with sink_valid[0] mirroring data_out_en one cycle late.
- Index values >= NUM_SRC never occur on cur, sel or owner.

Test Plan:
1. Reset, then src_valid[0]=1 with src_data[0]=0x41 held and data_read=0 → data_available=1 and data_in=0x41 one edge later. After that, src_ready=0 and data_in stays stable for 10 cycles.
2. BURST=1; both requesters valid with bytes 0x10/0x20; data_read held high → data_in sequence alternates 0x20 (src1), 0x10, 0x20, ... with data_available=1 every cycle. On edge 1, cur=0 at reset so src1 is scanned first.
3. BURST=3; both valid, data_read=1 → grant order 1,1,1,0,0,0,1,... Drop src_valid[1] after its first byte → grant moves to src0 at that edge.
4. Consume a byte from src1 (owner=1), then data_out_en=1 with data_out=0x7A → sink_valid=2'b10 and sink_data=0x7A one edge later. Strobe asserted before any input → sink_valid=2'b01.
5. Assert rst_n=0 for one edge while FULL mid-burst → data_available=0, owner=0, cnt=0. The next grant follows a fresh round-robin order.
6. data_read pulsed while EMPTY and no src_valid → no state change, all src_ready=0.
